hazard_scoreboard_unit: RTL
===========================

Name: hazard_scoreboard_unit

Overview:
Parametrised hazard unit for the 5-stage MIPS pipeline. It adds a multi-cycle mul/div sequencer on top of ID/EX forwarding, load-use and branch/jr dependency stalls, and control-transfer flush.
- While a mul/div occupies EX, it freezes F/D/E and bubbles M.
- All stall and flush decisions are centralised in this block.

Parameters:
- REG_AW, 5, register-address width; register 0 is hard-zero and never forwarded or stalled on.
- MD_LAT, 4, EX occupancy in cycles of a mul/div instruction. Legal values are >= 1; 1 disables holding.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- rs_d, rt_d  in  REG_AW  D-stage source registers
- rs_use_d, rt_use_d  in  1  D-stage instruction actually reads rs/rt
- branch_d, jr_d  in  1  D-stage branch / jr (operands compared in D)
- rs_e, rt_e  in  REG_AW  E-stage source registers
- wreg_e, wreg_m, wreg_w  in  REG_AW  destination register per stage
- regwrite_e, regwrite_m, regwrite_w  in  1  stage writes the register file
- memtoreg_e, memtoreg_m  in  1  stage holds a load
- md_start_e  in  1  E-stage instruction is mul/div
- pcsrc_d, jump_d  in  1  taken branch / j/jal/jr redirect resolved in D
- fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e  out  2  forward selects
- stall_f, stall_d, stall_e  out  1  hold PC / IF-ID / ID-EX
- flush_d, flush_e, flush_m  out  1  bubble IF-ID / ID-EX / EX-MEM
- md_busy  out  1  sequencer in BUSY
- perf_stall_cnt, perf_flush_cnt, perf_md_cnt  out  CNT_W  (see Optional Feature)

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.
- Forwarding (combinational), for each source s in {rs_e, rt_e, rs_d, rt_d}:
  - 2'b10 if regwrite_m & wreg_m!=0 & wreg_m==s;
  - else 2'b01 if regwrite_w & wreg_w!=0 & wreg_w==s;
  - else 2'b00.
  - M has priority over W.
- lu_stall = memtoreg_e & regwrite_e & wreg_e!=0 & ((rs_use_d & wreg_e==rs_d) | (rt_use_d & wreg_e==rt_d)).
- br_stall = (branch_d|jr_d) & (A | B), where:
  - A: regwrite_e & wreg_e!=0 matching a used D source;
  - B: memtoreg_m & wreg_m!=0 matching a used D source.
- Mul/div sequencer states: IDLE, BUSY. Counter cnt, width $clog2(MD_LAT) (min 1).
  - IDLE: md_hold = md_start_e & (MD_LAT>1). If md_hold, load cnt=MD_LAT-2 and go to BUSY.
  - BUSY: md_hold = (cnt!=0). If cnt!=0, decrement; else go to IDLE. md_start_e is ignored in BUSY, since the same instruction is still in EX.
  - Resulting EX occupancy is exactly MD_LAT cycles: hold on cycles 1..MD_LAT-1, release on cycle MD_LAT.
- md_busy = (state==BUSY), registered.
- Output priority, md_hold first:
  - md_hold: stall_f=stall_d=stall_e=1, flush_m=1, flush_e=0, flush_d=0. A redirect in D is re-evaluated after release.
  - else lu_stall|br_stall: stall_f=stall_d=1, flush_e=1, stall_e=0, flush_m=0, flush_d=0.
  - else: all stalls 0; flush_d = pcsrc_d|jump_d; flush_e=flush_m=0.
- Reset:
  - Reset values: state=IDLE, cnt=0, md_busy=0.
  - The combinational outputs are then zero unless the inputs demand otherwise.
  - Reset mid-BUSY aborts the hold; md_hold=0 from the next cycle.
- Simultaneous events:
  - md_start_e together with lu_stall: md_hold wins and no EX bubble is inserted.
  - Load-use together with a taken branch: stall wins; flush_d=0.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: three CNT_W-bit registers, cleared on rst, saturating at all-ones, increment once per cycle when their condition holds:
  - perf_stall_cnt when stall_f;
  - perf_flush_cnt when flush_d|flush_e;
  - perf_md_cnt when md_hold.
- Undefined: counters absent; ports remain and are tied to 0.

Decomposition:
- Shared package hazard_pkg:
  - forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - md state enum {MD_IDLE, MD_BUSY}.
- Sub-module md_sequencer (FSM + cnt).
  - Ports: clk, rst, md_start_e; outputs md_hold, md_busy.
  - Parameter: MD_LAT.

Test Plan:
- regwrite_m=1, wreg_m=5, regwrite_w=1, wreg_w=5, rs_e=5 -> fwd_a_e=2'b10. Repeat with wreg_m=0 -> 2'b01. Repeat with rs_e=0 -> 2'b00.
- memtoreg_e=regwrite_e=1, wreg_e=8, rs_d=8, rs_use_d=1 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle. With rs_use_d=0 -> no stall.
- branch_d=1, regwrite_e=1, wreg_e=3, rt_d=3, rt_use_d=1 -> stall 1 cycle. Then memtoreg_m=1, wreg_m=3 (E clear) -> stall 1 more cycle.
- MD_LAT=4, md_start_e held high -> md_hold/stall_e/flush_m high for cycles 1-3, low cycle 4; md_busy high cycles 2-4. Repeat with MD_LAT=1 -> never holds.
- Assert rst in the 2nd hold cycle -> next cycle md_busy=0 and all stalls 0. pcsrc_d=1 during hold -> flush_d=0; pcsrc_d=1 after release -> flush_d=1.
- HAZ_PERF_CNT_EN, CNT_W=4: force stall for 20 cycles -> perf_stall_cnt saturates at 15; rst -> 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared hazard-unit definitions: forward-select encodings and mul/div sequencer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;  // operand comes from the register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand bypassed from the W stage
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand bypassed from the M stage

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } mdState_t;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline <-> hazard unit bundle: stage register/control taps in, stall/flush/forward controls out.
// Latency: n/a (wires only).
// Backpressure: n/a; the hazard unit itself is the pipeline's backpressure source.
interface hazard_scoreboard_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    // D-stage operands
    logic [REG_AW-1:0] rs_d, rt_d;
    logic              rs_use_d, rt_use_d;
    logic              branch_d, jr_d;
    logic              pcsrc_d, jump_d;
    // E/M/W-stage taps
    logic [REG_AW-1:0] rs_e, rt_e;
    logic [REG_AW-1:0] wreg_e, wreg_m, wreg_w;
    logic              regwrite_e, regwrite_m, regwrite_w;
    logic              memtoreg_e, memtoreg_m;
    logic              md_start_e;
    // Controls back to the pipeline
    logic [1:0]        fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e;
    logic              stall_f, stall_d, stall_e;
    logic              flush_d, flush_e, flush_m;
    logic              md_busy;
    logic [CNT_W-1:0]  perf_stall_cnt, perf_flush_cnt, perf_md_cnt;

    // Pipeline side
    modport master (
        output rs_d, rt_d, rs_use_d, rt_use_d, branch_d, jr_d, pcsrc_d, jump_d,
               rs_e, rt_e, wreg_e, wreg_m, wreg_w,
               regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m, md_start_e,
        input  fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e,
               stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, md_busy,
               perf_stall_cnt, perf_flush_cnt, perf_md_cnt
    );

    // Hazard unit side
    modport slave (
        input  rs_d, rt_d, rs_use_d, rt_use_d, branch_d, jr_d, pcsrc_d, jump_d,
               rs_e, rt_e, wreg_e, wreg_m, wreg_w,
               regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m, md_start_e,
        output fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e,
               stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, md_busy,
               perf_stall_cnt, perf_flush_cnt, perf_md_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_unit_md_sequencer.sv
// Mul/div EX-occupancy sequencer: holds the instruction in EX for MD_LAT cycles in total.
// Latency: md_hold is combinational off state/md_start_e; md_busy is a registered state decode.
// Backpressure: md_hold asserts on occupancy cycles 1..MD_LAT-1; md_start_e is ignored while BUSY.
module md_sequencer
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start_e,
    output logic md_hold,
    output logic md_busy
);

    localparam int            CW       = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic          HOLD_EN  = (MD_LAT > 1);
    // First cycle is spent in IDLE, so BUSY needs MD_LAT-2 further hold cycles after the load.
    localparam logic [CW-1:0] CNT_LOAD = (MD_LAT > 1) ? CW'(MD_LAT - 2) : '0;

    mdState_t        state;
    logic [CW-1:0]   cnt;

    // Hold request: a new mul/div in IDLE, or remaining count while BUSY.
    always_comb begin
        md_hold = 1'b0;
        if (state == MD_IDLE) begin
            md_hold = md_start_e & HOLD_EN;
        end else begin
            md_hold = (cnt != '0);
        end
    end

    // State and countdown; the EX instruction is the same one throughout BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (md_hold) begin
                        state <= MD_BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                default: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state <= MD_IDLE;
                    end
                end
            endcase
        end
    end

    assign md_busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding, load-use/branch stalls, redirect flush, mul/div hold.
// Latency: all controls combinational from stage taps plus the registered mul/div sequencer state.
// Backpressure: mul/div hold freezes F/D/E and bubbles M; data hazards freeze F/D and bubble E.
// Build option: define HAZ_PERF_CNT_EN to include the saturating performance counters.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    hazard_scoreboard_unit_if.slave  hz
);

    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    localparam logic [CNT_W-1:0]  CNT_ZERO = '0;

    logic mdHold, mdBusy;
    logic depE, depM, luStall, brStall;
    logic stallF, stallD, stallE, flushD, flushE, flushM;

    // M-stage result is newer than W, so it wins; r0 never forwards.
    function automatic logic [1:0] fwdSel(
        input logic [REG_AW-1:0] src,
        input logic              rwM,
        input logic [REG_AW-1:0] wM,
        input logic              rwW,
        input logic [REG_AW-1:0] wW
    );
        if (rwM && (wM != REG_ZERO) && (wM == src)) begin
            return FWD_MEM;
        end else if (rwW && (wW != REG_ZERO) && (wW == src)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    md_sequencer #(.MD_LAT(MD_LAT)) u_mdSeq (
        .clk        (clk),
        .rst        (rst),
        .md_start_e (hz.md_start_e),
        .md_hold    (mdHold),
        .md_busy    (mdBusy)
    );

    // Forward selects for both D-stage (branch compare) and E-stage (ALU) operands.
    always_comb begin
        hz.fwd_a_e = fwdSel(hz.rs_e, hz.regwrite_m, hz.wreg_m, hz.regwrite_w, hz.wreg_w);
        hz.fwd_b_e = fwdSel(hz.rt_e, hz.regwrite_m, hz.wreg_m, hz.regwrite_w, hz.wreg_w);
        hz.fwd_a_d = fwdSel(hz.rs_d, hz.regwrite_m, hz.wreg_m, hz.regwrite_w, hz.wreg_w);
        hz.fwd_b_d = fwdSel(hz.rt_d, hz.regwrite_m, hz.wreg_m, hz.regwrite_w, hz.wreg_w);
    end

    // Data dependencies of the D-stage instruction on results not yet available.
    always_comb begin
        depE = (hz.wreg_e != REG_ZERO) &&
               ((hz.rs_use_d && (hz.wreg_e == hz.rs_d)) || (hz.rt_use_d && (hz.wreg_e == hz.rt_d)));
        depM = (hz.wreg_m != REG_ZERO) &&
               ((hz.rs_use_d && (hz.wreg_m == hz.rs_d)) || (hz.rt_use_d && (hz.wreg_m == hz.rt_d)));
        luStall = hz.memtoreg_e && hz.regwrite_e && depE;
        // Branch/jr compare in D, so an ALU result in E or a load in M is still too late.
        brStall = (hz.branch_d || hz.jr_d) && ((hz.regwrite_e && depE) || (hz.memtoreg_m && depM));
    end

    // Stall/flush priority: mul/div hold, then data stall, then redirect flush.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (mdHold) begin
            // Redirect in D is dropped here; it is seen again once EX releases.
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (luStall || brStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else begin
            flushD = hz.pcsrc_d || hz.jump_d;
        end
    end

    assign hz.stall_f = stallF;
    assign hz.stall_d = stallD;
    assign hz.stall_e = stallE;
    assign hz.flush_d = flushD;
    assign hz.flush_e = flushE;
    assign hz.flush_m = flushM;
    assign hz.md_busy = mdBusy;

`ifdef HAZ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] stallCnt, flushCnt, mdCnt;

    // Saturating event counters, one increment per cycle the event is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= CNT_ZERO;
            flushCnt <= CNT_ZERO;
            mdCnt    <= CNT_ZERO;
        end else begin
            if (stallF && (stallCnt != CNT_MAX)) stallCnt <= stallCnt + CNT_W'(1);
            if ((flushD || flushE) && (flushCnt != CNT_MAX)) flushCnt <= flushCnt + CNT_W'(1);
            if (mdHold && (mdCnt != CNT_MAX)) mdCnt <= mdCnt + CNT_W'(1);
        end
    end

    assign hz.perf_stall_cnt = stallCnt;
    assign hz.perf_flush_cnt = flushCnt;
    assign hz.perf_md_cnt    = mdCnt;
`else
    assign hz.perf_stall_cnt = CNT_ZERO;
    assign hz.perf_flush_cnt = CNT_ZERO;
    assign hz.perf_md_cnt    = CNT_ZERO;
`endif

endmodule
